// File: rtl/image_y_matrix_3x3_pkg.sv
`default_nettype none
// ============================================================================
// image_y_matrix_3x3_pkg : pixel types and address sizing for the 3x3 Y window
// Rev 1.0
// ============================================================================
package image_y_matrix_3x3_pkg;

  localparam int PIX_W = 8;

  typedef logic [PIX_W-1:0] pix_t;

  typedef struct packed {
    logic vsync;
    logic href;
    logic clken;
  } sync_t;

  // Bits needed to address `depth` entries, never less than one.
  function automatic int addr_width(input int depth);
    int w;
    w = 1;
    while ((1 << w) < depth) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/image_y_matrix_3x3_if.sv
`default_nettype none
// ============================================================================
// image_y_matrix_3x3_if : Y pixel stream in, 3x3 window with delayed syncs out
// Rev 1.0
// ============================================================================
interface image_y_matrix_3x3_if;
  import image_y_matrix_3x3_pkg::*;

  logic per_frame_vsync;
  logic per_frame_href;
  logic per_frame_clken;
  pix_t per_img_Y;

  logic matrix_frame_vsync;
  logic matrix_frame_href;
  logic matrix_frame_clken;
  pix_t matrix_p11;
  pix_t matrix_p12;
  pix_t matrix_p13;
  pix_t matrix_p21;
  pix_t matrix_p22;
  pix_t matrix_p23;
  pix_t matrix_p31;
  pix_t matrix_p32;
  pix_t matrix_p33;

  modport master (
    output per_frame_vsync, per_frame_href, per_frame_clken, per_img_Y,
    input  matrix_frame_vsync, matrix_frame_href, matrix_frame_clken,
    input  matrix_p11, matrix_p12, matrix_p13,
    input  matrix_p21, matrix_p22, matrix_p23,
    input  matrix_p31, matrix_p32, matrix_p33
  );

  modport slave (
    input  per_frame_vsync, per_frame_href, per_frame_clken, per_img_Y,
    output matrix_frame_vsync, matrix_frame_href, matrix_frame_clken,
    output matrix_p11, matrix_p12, matrix_p13,
    output matrix_p21, matrix_p22, matrix_p23,
    output matrix_p31, matrix_p32, matrix_p33
  );

endinterface
`default_nettype wire

// File: rtl/image_line_buffer.sv
`default_nettype none
// ============================================================================
// image_line_buffer : simple dual-port line RAM, registered read-before-write
// Rev 1.0
// ============================================================================
module image_line_buffer
  import image_y_matrix_3x3_pkg::*;
#(
  parameter int DEPTH  = 640,
  parameter int ADDR_W = addr_width(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  pix_t              wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output pix_t              rd_data
);

  pix_t mem [DEPTH];

  // Storage is deliberately left unreset; only the read register clears.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data <= '0;
    end else begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule
`default_nettype wire

// File: rtl/image_y_matrix_3x3.sv
`default_nettype none
// ============================================================================
// image_y_matrix_3x3 : 3x3 luminance window from a raster Y stream, 2 clk latency
// Option macro: IMAGE_MATRIX_ZERO_PAD_EN (zero the rows above the frame top)
// Rev 1.0
// ============================================================================
module image_y_matrix_3x3
  import image_y_matrix_3x3_pkg::*;
#(
  parameter int IMG_HDISP = 640,
  parameter int IMG_VDISP = 480
) (
  input logic               clk,
  input logic               rst,
  image_y_matrix_3x3_if.slave img
);

  localparam int               COL_W    = addr_width(IMG_HDISP);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_HDISP - 1);

  sync_t            sync_in;
  sync_t            sync_d1;
  sync_t            sync_d2;
  logic             accept;
  logic             accept_d1;
  logic [COL_W-1:0] col_addr;
  logic [COL_W-1:0] col_addr_d1;
  pix_t             row1_d;
  pix_t             row2_d;
  pix_t             row3_d;
  pix_t             row1_in;
  pix_t             row2_in;
  pix_t             new_col [3];
  pix_t             win [3][3];

  assign sync_in   = {img.per_frame_vsync, img.per_frame_href, img.per_frame_clken};
  assign accept    = sync_in.href & sync_in.clken;
  assign accept_d1 = sync_d1.href & sync_d1.clken;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_addr <= '0;
    end else if (!sync_in.href) begin
      col_addr <= '0;
    end else if (accept) begin
      col_addr <= (col_addr == COL_LAST) ? '0 : col_addr + COL_W'(1);
    end
  end

  // Stage 1: current pixel and sync captured alongside the buffer reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_d1     <= '0;
      col_addr_d1 <= '0;
      row3_d      <= '0;
    end else begin
      sync_d1     <= sync_in;
      col_addr_d1 <= col_addr;
      row3_d      <= img.per_img_Y;
    end
  end

  image_line_buffer #(
    .DEPTH  (IMG_HDISP),
    .ADDR_W (COL_W)
  ) u_line_buf0 (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (accept),
    .wr_addr (col_addr),
    .wr_data (img.per_img_Y),
    .rd_addr (col_addr),
    .rd_data (row2_d)
  );

  // The older line is fed from the newer buffer's old word one cycle later.
  image_line_buffer #(
    .DEPTH  (IMG_HDISP),
    .ADDR_W (COL_W)
  ) u_line_buf1 (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (accept_d1),
    .wr_addr (col_addr_d1),
    .wr_data (row2_d),
    .rd_addr (col_addr),
    .rd_data (row1_d)
  );

`ifdef IMAGE_MATRIX_ZERO_PAD_EN
  localparam int               ROW_W    = addr_width(IMG_VDISP);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_VDISP - 1);

  logic [ROW_W-1:0] row_cnt;
  logic [ROW_W-1:0] row_cnt_d1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_cnt <= '0;
    end else if (!sync_in.vsync) begin
      row_cnt <= '0;
    end else if (sync_d1.href && !sync_in.href && (row_cnt != ROW_LAST)) begin
      row_cnt <= row_cnt + ROW_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_cnt_d1 <= '0;
    end else begin
      row_cnt_d1 <= row_cnt;
    end
  end

  assign row1_in = (int'(row_cnt_d1) < 2) ? '0 : row1_d;
  assign row2_in = (int'(row_cnt_d1) < 1) ? '0 : row2_d;
`else
  assign row1_in = row1_d;
  assign row2_in = row2_d;
`endif

  always_comb begin
    new_col[0] = row1_in;
    new_col[1] = row2_in;
    new_col[2] = row3_d;
  end

  // Stage 2: clearing on href low gives each line a zero left border.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win[r][c] <= '0;
        end
      end
    end else if (!sync_d1.href) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win[r][c] <= '0;
        end
      end
    end else if (sync_d1.clken) begin
      for (int r = 0; r < 3; r++) begin
        win[r][0] <= win[r][1];
        win[r][1] <= win[r][2];
        win[r][2] <= new_col[r];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_d2 <= '0;
    end else begin
      sync_d2 <= sync_d1;
    end
  end

  assign img.matrix_frame_vsync = sync_d2.vsync;
  assign img.matrix_frame_href  = sync_d2.href;
  assign img.matrix_frame_clken = sync_d2.clken;

  assign img.matrix_p11 = win[0][0];
  assign img.matrix_p12 = win[0][1];
  assign img.matrix_p13 = win[0][2];
  assign img.matrix_p21 = win[1][0];
  assign img.matrix_p22 = win[1][1];
  assign img.matrix_p23 = win[1][2];
  assign img.matrix_p31 = win[2][0];
  assign img.matrix_p32 = win[2][1];
  assign img.matrix_p33 = win[2][2];

endmodule
`default_nettype wire

// File: tb/tb_image_y_matrix_3x3.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_image_y_matrix_3x3 : random frames checked against a per-column history model
// Rev 1.0
// ============================================================================
module tb_image_y_matrix_3x3;
  import image_y_matrix_3x3_pkg::*;

  localparam int H         = 4;
  localparam int V         = 4;
  localparam int RST_FRAME = 6;
`ifdef IMAGE_MATRIX_ZERO_PAD_EN
  localparam int PAD = 1;
`else
  localparam int PAD = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  image_y_matrix_3x3_if img();

  image_y_matrix_3x3 #(
    .IMG_HDISP (H),
    .IMG_VDISP (V)
  ) dut (
    .clk (clk),
    .rst (rst),
    .img (img)
  );

  int total = 0;
  int bad   = 0;
  int drv_f = -1;
  int drv_r = -1;
  int drv_c = -1;

  // Model: the two most recent values seen at each column (-1 = never written).
  int h1 [H];
  int h2 [H];
  int col, row, prev_hr;
  int s_vs, s_hr, s_ce, s_y;
  int p_vs, p_hr, p_ce, p_f, p_r, p_c;
  int p_tap [3];
  int e_vs, e_hr, e_ce, e_f, e_r, e_c;
  int e_win [3][3];
  bit model_on = 1'b0;

  function automatic logic [7:0] tap(input int r, input int c);
    case (r * 3 + c)
      0:       return img.matrix_p11;
      1:       return img.matrix_p12;
      2:       return img.matrix_p13;
      3:       return img.matrix_p21;
      4:       return img.matrix_p22;
      5:       return img.matrix_p23;
      6:       return img.matrix_p31;
      7:       return img.matrix_p32;
      default: return img.matrix_p33;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    total++;
    if (act !== 32'(exp)) begin
      bad++;
      $display("FAIL %s: dut=%0d want=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic lit(input string nm, input int r, input int c, input int v);
    chk($sformatf("%s p%0d%0d", nm, r + 1, c + 1), {24'd0, tap(r, c)}, v);
  endtask

  always @(posedge clk) begin
    if (rst) begin
      model_on = 1'b1;
      e_vs = 0; e_hr = 0; e_ce = 0; e_f = -1; e_r = -1; e_c = -1;
      p_vs = 0; p_hr = 0; p_ce = 0; p_f = -1; p_r = -1; p_c = -1;
      for (int r = 0; r < 3; r++) begin
        p_tap[r] = 0;
        for (int c = 0; c < 3; c++) e_win[r][c] = 0;
      end
      col = 0; row = 0; prev_hr = 0;
    end else begin
      // what becomes visible after this edge: the pixel sampled one edge ago
      e_vs = p_vs; e_hr = p_hr; e_ce = p_ce; e_f = -1;
      if (p_hr == 0) begin
        for (int r = 0; r < 3; r++)
          for (int c = 0; c < 3; c++) e_win[r][c] = 0;
      end else if (p_ce != 0) begin
        for (int r = 0; r < 3; r++) begin
          e_win[r][0] = e_win[r][1];
          e_win[r][1] = e_win[r][2];
          e_win[r][2] = p_tap[r];
        end
        e_f = p_f; e_r = p_r; e_c = p_c;
      end
      s_vs = int'(img.per_frame_vsync);
      s_hr = int'(img.per_frame_href);
      s_ce = int'(img.per_frame_clken);
      s_y  = int'(img.per_img_Y);
      p_vs = s_vs; p_hr = s_hr; p_ce = s_ce; p_f = -1;
      if (s_hr != 0 && s_ce != 0) begin
        p_tap[2] = s_y;
        p_tap[1] = (PAD != 0 && row < 1) ? 0 : h1[col];
        p_tap[0] = (PAD != 0 && row < 2) ? 0 : h2[col];
        h2[col]  = h1[col];
        h1[col]  = s_y;
        p_f = drv_f; p_r = drv_r; p_c = drv_c;
        col = (col + 1) % H;
      end else if (s_hr == 0) begin
        col = 0;
      end
      if (s_vs == 0) row = 0;
      else if (prev_hr != 0 && s_hr == 0 && row < V - 1) row++;
      prev_hr = s_hr;
    end
  end

  task automatic pin_literals();
    int k9 [9];
    k9 = '{1, 2, 3, 11, 12, 13, 21, 22, 23};
    if ((e_f == 0 || e_f == RST_FRAME) && e_r == 0 && e_c == 0) begin
      lit("first", 2, 2, 1);
      lit("first", 2, 1, 0);
      lit("first", 2, 0, 0);
      lit("first", 1, 1, 0);
      lit("first", 1, 0, 0);
      lit("first", 0, 1, 0);
      lit("first", 0, 0, 0);
`ifdef IMAGE_MATRIX_ZERO_PAD_EN
      lit("first", 1, 2, 0);
      lit("first", 0, 2, 0);
`endif
      chk("first clken", img.matrix_frame_clken, 1);
    end
    if (e_f == 0 && e_r == 1 && e_c == 1) begin
      lit("px11", 2, 0, 0);
      lit("px11", 2, 1, 11);
      lit("px11", 2, 2, 12);
      lit("px11", 1, 0, 0);
      lit("px11", 1, 1, 1);
      lit("px11", 1, 2, 2);
      lit("px11", 0, 0, 0);
`ifdef IMAGE_MATRIX_ZERO_PAD_EN
      lit("px11", 0, 1, 0);
      lit("px11", 0, 2, 0);
`endif
    end
    if (e_f == 0 && e_r == 2 && e_c == 2) begin
      for (int i = 0; i < 9; i++) lit("px22", i / 3, i % 3, k9[i]);
    end
    if (e_f == 1 && e_r == 0 && e_c == 2) begin
      for (int c = 0; c < 3; c++) begin
        lit("frame2 row3", 2, c, c + 1);
`ifdef IMAGE_MATRIX_ZERO_PAD_EN
        lit("frame2 padded", 0, c, 0);
        lit("frame2 padded", 1, c, 0);
`else
        lit("frame2 stale", 0, c, 21 + c);
        lit("frame2 stale", 1, c, 31 + c);
`endif
      end
    end
  endtask

  always @(posedge clk) begin
    #2;
    if (model_on) begin
      chk("vsync", img.matrix_frame_vsync, e_vs);
      chk("href", img.matrix_frame_href, e_hr);
      chk("clken", img.matrix_frame_clken, e_ce);
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          if (e_win[r][c] >= 0)
            chk($sformatf("tap p%0d%0d", r + 1, c + 1), {24'd0, tap(r, c)}, e_win[r][c]);
      pin_literals();
    end
  end

  task automatic drive(input bit vs, input bit hr, input bit ce, input int y,
                       input int f, input int r, input int c);
    @(negedge clk);
    img.per_frame_vsync = vs;
    img.per_frame_href  = hr;
    img.per_frame_clken = ce;
    img.per_img_Y       = 8'(y);
    drv_f = f; drv_r = r; drv_c = c;
  endtask

  task automatic idle(input bit vs, input int n);
    for (int i = 0; i < n; i++)
      drive(vs, 1'b0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 255)), -1, -1, -1);
  endtask

  task automatic send_frame(input int f, input int lines, input bit rnd_data,
                            input bit rnd_gap, input int gap_row, input int long_row);
    idle(1'b1, 2);
    for (int r = 0; r < lines; r++) begin
      int len;
      len = (r == long_row) ? H + 1 : H;
      for (int c = 0; c < len; c++) begin
        if (rnd_gap)
          while ($urandom_range(0, 3) == 0)
            drive(1'b1, 1'b1, 1'b0, int'($urandom_range(0, 255)), -1, -1, -1);
        if (r == gap_row && c == 2)
          repeat (3) drive(1'b1, 1'b1, 1'b0, 0, -1, -1, -1);
        drive(1'b1, 1'b1, 1'b1,
              rnd_data ? int'($urandom_range(0, 255)) : 10 * r + c + 1, f, r, c);
      end
      idle(1'b1, int'($urandom_range(1, 3)));
    end
    idle(1'b0, 3);
  endtask

  initial begin
    for (int i = 0; i < H; i++) begin
      h1[i] = -1;
      h2[i] = -1;
    end
    img.per_frame_vsync = 1'b0;
    img.per_frame_href  = 1'b0;
    img.per_frame_clken = 1'b0;
    img.per_img_Y       = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle(1'b0, 3);

    send_frame(0, V, 1'b0, 1'b0, 2, -1);
    send_frame(1, V, 1'b0, 1'b1, -1, -1);
    send_frame(2, V, 1'b1, 1'b1, -1, -1);
    send_frame(3, 6, 1'b1, 1'b1, -1, 1);
    send_frame(4, 3, 1'b1, 1'b1, -1, -1);
    send_frame(5, V, 1'b1, 1'b1, -1, 2);

    // reset in the middle of a line, after the last pixel has settled
    idle(1'b1, 2);
    drive(1'b1, 1'b1, 1'b1, 200, -1, -1, -1);
    drive(1'b1, 1'b1, 1'b1, 201, -1, -1, -1);
    drive(1'b1, 1'b1, 0, 0, -1, -1, -1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #2;
    for (int i = 0; i < 9; i++) lit("reset", i / 3, i % 3, 0);
    chk("reset vsync", img.matrix_frame_vsync, 0);
    chk("reset href", img.matrix_frame_href, 0);
    chk("reset clken", img.matrix_frame_clken, 0);
    drive(1'b1, 1'b1, 1'b0, 0, -1, -1, -1);
    idle(1'b0, 1);
    rst = 1'b0;
    idle(1'b0, 3);

    send_frame(RST_FRAME, V, 1'b0, 1'b0, -1, -1);
    send_frame(7, 5, 1'b1, 1'b1, -1, 3);
    send_frame(8, V, 1'b1, 1'b1, -1, -1);
    idle(1'b0, 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
